// File: rtl/display_capture_pkg.sv
// Shared constants and types for the seven-segment display capture block.
// Macro DISPLAY_CAPTURE_HEX_EN enables decoding of A..F glyphs.
package display_capture_pkg;

  // Lit-segment patterns, bit6=a ... bit0=g.
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h01;

  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_DASH  = 5'd17;

`ifdef DISPLAY_CAPTURE_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    OCIOSO,
    ESTABILIZA,
    AMOSTRADO
  } state_t;

  function automatic logic one_hot(input logic [4:0] v);
    return (v != '0) && ((v & (v - 5'd1)) == '0);
  endfunction

endpackage

// File: rtl/display_capture_seg_decode.sv
// Combinational seven-segment to digit-code decoder (active-low input).
// A..F decode only when DISPLAY_CAPTURE_HEX_EN is defined.
module seg_decode
  import display_capture_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [4:0] code_o,
  output logic       valid_o
);

  logic [6:0] lit;
  assign lit = ~seg_n_i;

  // Map a lit-segment pattern to its code; unknown glyphs are invalid.
  always_comb begin
    code_o  = '0;
    valid_o = 1'b1;
    unique case (lit)
      SEG_0:     code_o = 5'd0;
      SEG_1:     code_o = 5'd1;
      SEG_2:     code_o = 5'd2;
      SEG_3:     code_o = 5'd3;
      SEG_4:     code_o = 5'd4;
      SEG_5:     code_o = 5'd5;
      SEG_6:     code_o = 5'd6;
      SEG_7:     code_o = 5'd7;
      SEG_8:     code_o = 5'd8;
      SEG_9:     code_o = 5'd9;
      SEG_A:     begin code_o = 5'd10; valid_o = HEX_EN; end
      SEG_B:     begin code_o = 5'd11; valid_o = HEX_EN; end
      SEG_C:     begin code_o = 5'd12; valid_o = HEX_EN; end
      SEG_D:     begin code_o = 5'd13; valid_o = HEX_EN; end
      SEG_E:     begin code_o = 5'd14; valid_o = HEX_EN; end
      SEG_F:     begin code_o = 5'd15; valid_o = HEX_EN; end
      SEG_BLANK: code_o = CODE_BLANK;
      SEG_DASH:  code_o = CODE_DASH;
      default:   valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Captures a multiplexed 5-digit seven-segment display into digit codes.
// Build option: DISPLAY_CAPTURE_HEX_EN (see display_capture_pkg).
module display_capture
  import display_capture_pkg::*;
#(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 500000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  BITS_DIGITOS,
  input  logic [6:0]  BITS_SEGMENTOS,
  output logic [24:0] VALORES,
  output logic [4:0]  VALIDO,
  output logic        QUADRO,
  output logic        ERRO
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          st_q;
  logic [SW-1:0]   set_q;
  logic [TW-1:0]   idle_q;
  logic [4:0]      cur_q;
  logic [4:0]      seen_q;
  logic [4:0]      pvld_q;
  logic [4:0][4:0] pend_q;
  logic [4:0][4:0] val_q;
  logic [4:0]      vld_q;
  logic            quadro_q;
  logic            erro_q;
  logic            qpend_q;
  logic            coll_q;

  logic [4:0] sel;
  logic       none;
  logic       single;
  logic       coll;
  logic [4:0] dcode;
  logic       dvalid;
  logic       sample;
  logic [4:0] seen_d;
  logic       full;
  logic       err_now;
  logic       q_req;
  logic       tmo;

  seg_decode u_dec (
    .seg_n_i (BITS_SEGMENTOS),
    .code_o  (dcode),
    .valid_o (dvalid)
  );

  assign sel     = ~BITS_DIGITOS;
  assign none    = (sel == '0);
  assign single  = one_hot(sel);
  assign coll    = !none && !single;
  assign sample  = (st_q == ESTABILIZA) && single && (sel == cur_q)
                && (set_q == SW'(SETTLE - 1));
  assign seen_d  = seen_q | cur_q;
  assign full    = sample && (seen_d == 5'h1F);
  // A collision only reports once, on its first cycle.
  assign err_now = (coll && !coll_q) || (sample && !dvalid);
  assign q_req   = full || qpend_q;
  assign tmo     = (st_q == OCIOSO) && none
                && (idle_q == TW'(TIMEOUT - 1));

  assign VALORES = val_q;
  assign VALIDO  = vld_q;
  assign QUADRO  = quadro_q;
  assign ERRO    = erro_q;

  // Scan FSM: settle on a single digit select, sample once, wait for change.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q   <= OCIOSO;
      set_q  <= '0;
      idle_q <= '0;
      cur_q  <= '0;
    end else begin
      unique case (st_q)
        OCIOSO: begin
          if (single) begin
            st_q   <= ESTABILIZA;
            set_q  <= '0;
            cur_q  <= sel;
            idle_q <= '0;
          end else if (coll) begin
            idle_q <= '0;
          end else if (idle_q != TW'(TIMEOUT)) begin
            idle_q <= idle_q + TW'(1);
          end
        end
        ESTABILIZA: begin
          if (!single) begin
            st_q <= OCIOSO;
          end else if (sel != cur_q) begin
            cur_q <= sel;
            set_q <= '0;
          end else if (sample) begin
            st_q <= AMOSTRADO;
          end else begin
            set_q <= set_q + SW'(1);
          end
        end
        AMOSTRADO: begin
          if (!single) begin
            st_q <= OCIOSO;
          end else if (sel != cur_q) begin
            st_q  <= ESTABILIZA;
            cur_q <= sel;
            set_q <= '0;
          end
        end
        default: st_q <= OCIOSO;
      endcase
    end
  end

  // Confirmation, seen mask, timeout and registered status pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seen_q   <= '0;
      pvld_q   <= '0;
      pend_q   <= '0;
      val_q    <= '0;
      vld_q    <= '0;
      quadro_q <= 1'b0;
      erro_q   <= 1'b0;
      qpend_q  <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      coll_q   <= coll;
      erro_q   <= err_now;
      quadro_q <= q_req && !err_now;
      qpend_q  <= q_req && err_now;
      if (tmo) begin
        vld_q  <= '0;
        pvld_q <= '0;
        seen_q <= '0;
      end
      if (sample) begin
        seen_q <= full ? 5'h00 : seen_d;
        for (int n = 0; n < 5; n++) begin
          if (cur_q[n]) begin
            if (!dvalid) begin
              pvld_q[n] <= 1'b0;
            end else if (pvld_q[n] && (pend_q[n] == dcode)) begin
              val_q[n] <= dcode;
              vld_q[n] <= 1'b1;
            end else begin
              pend_q[n] <= dcode;
              pvld_q[n] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_display_capture.sv
// Scoreboard bench for display_capture: expected events queued by stimulus,
// popped by a monitor on QUADRO, ERRO or an explicit snapshot request.
module tb_display_capture;

  localparam int TMO    = 40;
  localparam int K_QUAD = 0;
  localparam int K_ERR  = 1;
  localparam int K_SNAP = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  BITS_DIGITOS;
  logic [6:0]  BITS_SEGMENTOS;
  logic [24:0] VALORES;
  logic [4:0]  VALIDO;
  logic        QUADRO;
  logic        ERRO;

  display_capture #(.SETTLE(4), .TIMEOUT(TMO)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .BITS_DIGITOS   (BITS_DIGITOS),
    .BITS_SEGMENTOS (BITS_SEGMENTOS),
    .VALORES        (VALORES),
    .VALIDO         (VALIDO),
    .QUADRO         (QUADRO),
    .ERRO           (ERRO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    int          kind;
    logic [24:0] val;
    logic [4:0]  vld;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   snap_req = 1'b0;

  function automatic string kname(input int k);
    if (k == K_QUAD) return "quadro";
    if (k == K_ERR)  return "erro";
    return "snapshot";
  endfunction

  function automatic logic [24:0] pack5(input int d4, input int d3,
                                        input int d2, input int d1,
                                        input int d0);
    return {5'(d4), 5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endfunction

  task automatic expect_ev(input string nm, input int k,
                           input logic [24:0] v, input logic [4:0] m);
    exp_t e;
    e.name = nm;
    e.kind = k;
    e.val  = v;
    e.vld  = m;
    q.push_back(e);
  endtask

  task automatic judge(input int k);
    exp_t e;
    n_checks++;
    if (q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_%s: got VALORES=%h VALIDO=%b, required no event",
               kname(k), VALORES, VALIDO);
    end else begin
      e = q.pop_front();
      if (e.kind != k || VALORES !== e.val || VALIDO !== e.vld) begin
        n_errors++;
        $display("FAIL %s: got %s VALORES=%h VALIDO=%b, required %s VALORES=%h VALIDO=%b",
                 e.name, kname(k), VALORES, VALIDO,
                 kname(e.kind), e.val, e.vld);
      end
    end
  endtask

  // Monitor: compare on every output event, away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (ERRO === 1'b1) judge(K_ERR);
      if (QUADRO === 1'b1) judge(K_QUAD);
      if (snap_req) begin
        judge(K_SNAP);
        snap_req = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic snap(input string nm, input logic [24:0] v,
                      input logic [4:0] m);
    expect_ev(nm, K_SNAP, v, m);
    snap_req = 1'b1;
    tick(1);
  endtask

  task automatic idle(input int n);
    BITS_DIGITOS   = 5'b11111;
    BITS_SEGMENTOS = 7'h7F;
    tick(n);
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                      input logic [6:0] p2, input logic [6:0] p3,
                      input logic [6:0] p4);
    logic [6:0] pats [5];
    logic [4:0] one;
    pats = '{p0, p1, p2, p3, p4};
    for (int i = 0; i < 5; i++) begin
      one            = 5'b00001 << i;
      BITS_DIGITOS   = ~one;
      BITS_SEGMENTOS = ~pats[i];
      tick(7);
    end
  endtask

  localparam logic [6:0] P1 = 7'h30;
  localparam logic [6:0] P2 = 7'h6D;
  localparam logic [6:0] P3 = 7'h79;
  localparam logic [6:0] P5 = 7'h5B;
  localparam logic [6:0] P6 = 7'h5F;
  localparam logic [6:0] PB = 7'h1F;
  localparam logic [6:0] PD = 7'h01;
  localparam logic [6:0] PZ = 7'h00;

  logic [24:0] v1;
  logic [24:0] v2;
  logic [24:0] v3;

  initial begin
    v1 = pack5(16, 17, 3, 2, 1);
    v2 = pack5(16, 17, 6, 2, 1);
    v3 = pack5(16, 17, 6, 11, 1);
    RST            = 1'b1;
    BITS_DIGITOS   = 5'b11111;
    BITS_SEGMENTOS = 7'h7F;
    tick(3);
    RST = 1'b0;
    snap("reset_state", 25'h0, 5'b00000);

    expect_ev("scan1_quadro", K_QUAD, 25'h0, 5'b00000);
    scan(P1, P2, P3, PD, PZ);
    expect_ev("scan2_quadro", K_QUAD, v1, 5'b11111);
    scan(P1, P2, P3, PD, PZ);
    idle(3);
    snap("two_scans", v1, 5'b11111);

    expect_ev("digit2_five", K_QUAD, v1, 5'b11111);
    scan(P1, P2, P5, PD, PZ);
    expect_ev("digit2_six_first", K_QUAD, v1, 5'b11111);
    scan(P1, P2, P6, PD, PZ);
    expect_ev("digit2_six_confirm", K_QUAD, v2, 5'b11111);
    scan(P1, P2, P6, PD, PZ);
    idle(3);

    expect_ev("collision", K_ERR, v2, 5'b11111);
    BITS_DIGITOS = 5'b11100;
    tick(10);
    idle(3);
    snap("after_collision", v2, 5'b11111);

    BITS_DIGITOS   = 5'b11110;
    BITS_SEGMENTOS = ~P2;
    tick(3);
    BITS_DIGITOS = 5'b11101;
    tick(3);
    idle(3);
    snap("short_select", v2, 5'b11111);

    idle(TMO + 5);
    snap("timeout", v2, 5'b00000);

`ifdef DISPLAY_CAPTURE_HEX_EN
    expect_ev("hex_b_scan1", K_QUAD, v2, 5'b00000);
    scan(P1, PB, P6, PD, PZ);
    expect_ev("hex_b_scan2", K_QUAD, v3, 5'b11111);
    scan(P1, PB, P6, PD, PZ);
`else
    expect_ev("b_invalid1", K_ERR, v2, 5'b00000);
    expect_ev("b_scan1", K_QUAD, v2, 5'b00000);
    scan(P1, PB, P6, PD, PZ);
    expect_ev("b_invalid2", K_ERR, v2, 5'b00001);
    expect_ev("b_scan2", K_QUAD, v2, 5'b11101);
    scan(P1, PB, P6, PD, PZ);
`endif
    idle(3);

    BITS_DIGITOS   = 5'b11011;
    BITS_SEGMENTOS = ~P2;
    tick(2);
    RST = 1'b1;
    tick(1);
    snap("reset_mid_settle", 25'h0, 5'b00000);
    RST = 1'b0;
    idle(5);

    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_events: got %0d events left over, required 0 (next %s)",
               q.size(), q[0].name);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1);
  end

endmodule

// File: doc/display_capture.md
DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 SHALL have parameter SETTLE, default 4: clock cycles a digit select must stay stable before segments are sampled.
REQ-002 SHALL have parameter TIMEOUT, default 500000: cycles without any digit select before all digits are invalidated.
REQ-003 SHALL have port CLK, input, 1, the single clock. Rising edge only.
REQ-004 SHALL have port RST, input, 1, reset. Synchronous, active-high.
REQ-005 SHALL have port BITS_DIGITOS, input, 5, digit enables. Active-low; bit n selects digit n.
REQ-006 SHALL have port BITS_SEGMENTOS, input, 7, segments. Active-low; bit6=a … bit0=g.
REQ-007 SHALL have port VALORES, output, 25, five 5-bit digit codes; digit n is at [5n+4:5n]. Codes: 0–15 value, 16 blank, 17 dash.
REQ-008 SHALL have port VALIDO, output, 5, per-digit flag: the code has been confirmed.
REQ-009 SHALL have port QUADRO, output, 1, one-cycle pulse when a full scan completes.
REQ-010 SHALL have port ERRO, output, 1, one-cycle pulse on a protocol or decode error.

Function
REQ-011 SHALL run an FSM with states OCIOSO, ESTABILIZA, AMOSTRADO.
- OCIOSO: no digit selected.
- ESTABILIZA: one digit selected; settle counter running.
- AMOSTRADO: sample taken; waiting for the select to change.
REQ-012 SHALL go from OCIOSO to ESTABILIZA when exactly one BITS_DIGITOS bit is low, loading the settle counter with 0.
REQ-013 SHALL, in ESTABILIZA, restart the counter if the selected digit changes; after SETTLE consecutive stable cycles, sample BITS_SEGMENTOS and go to AMOSTRADO.
REQ-014 SHALL, in AMOSTRADO, return to OCIOSO when all selects are high, or to ESTABILIZA when a different single digit is selected.
REQ-015 SHALL treat more than one low select bit as a collision:
- pulse ERRO;
- no sample taken;
- FSM goes to OCIOSO.
REQ-016 SHALL decode segments through seg_decode:
- standard 0–9 patterns → 0–9;
- all segments off → 16;
- only g lit → 17;
- any other pattern → invalid.
REQ-017 SHALL confirm a digit only when the same valid code is sampled on two consecutive scans of that digit.
- On confirmation: update that VALORES field and set its VALIDO bit.
- An unconfirmed differing sample replaces the pending code and leaves the output unchanged.
REQ-018 SHALL, for an invalid pattern: pulse ERRO, clear that digit's pending code, and leave VALORES and VALIDO for that digit unchanged.
REQ-019 SHALL keep a 5-bit seen mask, setting bit n on each sample of digit n.
- When the mask reaches 5'b11111: pulse QUADRO one cycle after the completing sample and clear the mask.
- If a digit is sampled again before the mask completes: keep the mask; no error.
REQ-020 SHALL count cycles spent in OCIOSO. At TIMEOUT: clear VALIDO, the pending codes and the seen mask; VALORES keeps its value. The counter restarts on the next select.
REQ-021 SHALL register all outputs. Latency from the sampling cycle to the VALORES/VALIDO update is 1 cycle.
REQ-022 SHALL give ERRO priority over QUADRO in the same cycle: QUADRO is deferred one cycle, never lost.

Reset
REQ-023 SHALL set on RST:
- FSM to OCIOSO, all counters to 0, seen mask and pending codes cleared;
- VALORES=25'h0, VALIDO=5'b0, QUADRO=0, ERRO=0.
REQ-024 SHALL give RST priority over every other event, including mid-settle and mid-scan; the first sample after reset needs a full SETTLE period.

Configuration
REQ-025 SHALL support macro DISPLAY_CAPTURE_HEX_EN.
- Defined: patterns A, b, C, d, E, F decode to 10–15.
- Undefined: those patterns are invalid per REQ-018.

Structure
REQ-026 SHALL place the following in package display_capture_pkg:
- segment pattern constants;
- code constants (blank=16, dash=17);
- the FSM state typedef.
REQ-027 SHALL implement decoding in a combinational sub-module seg_decode (7-bit segments in; 5-bit code plus valid out).

Verification
REQ-028 SHALL cover these directed scenarios:
- Scan digits 0–4 with patterns "1","2","3","-",blank for two scans, SETTLE=4 → VALORES={17'h..} fields 1,2,3,17,16; VALIDO=5'b11111; QUADRO pulses once per scan.
- Digit 2 shows "5" on one scan, then "6" on two scans → field 2 never equals 5; field 2 becomes 6 after the second scan of 6.
- BITS_DIGITOS=5'b11100 for 10 cycles → ERRO pulses once; no field changes.
- Pattern for "b" on digit 1 → with DISPLAY_CAPTURE_HEX_EN, field 1=11 after confirmation; without the macro, ERRO pulses and VALIDO[1] stays 0.
- Select held 3 cycles then switched, SETTLE=4 → no sample taken; ERRO stays 0.
- All selects high for TIMEOUT cycles after a valid scan → VALIDO=0 and VALORES held; RST asserted mid-ESTABILIZA → all outputs 0 the next cycle.
